// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked, registered ALU with a multi-cycle multiply engine.
//
// Sits between the operand register file and the writeback stage. A command
// (op_a, op_b, op_sel) is taken when in_valid && in_ready. Logic/add/sub
// results appear one cycle after acceptance. Multiply (and divide, when built
// in) iterates one bit per cycle in a shift-add / restoring-subtract engine,
// which gives WIDTH+1 cycles of latency.
//
// Optional feature: define ALU_SEQ_DIV_EN to enable opcode 110 as unsigned
// restoring division. Without the macro, 110 behaves as a reserved opcode.
//
// Parameters:
//   WIDTH      operand width, 4..32; result is 2*WIDTH bits
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   command presented
//   in_ready   command can be accepted this cycle
//   op_a/op_b  unsigned operands
//   op_sel     000 add, 001 sub, 010 and, 011 or, 100 mul, 101 xor,
//              110 div (or reserved), 111 reserved
//   out_valid  result and flags valid
//   out_ready  downstream accepts the result
//   result     2*WIDTH-bit result, zero-extended for narrow ops
//   zero_flag  result == 0 over all 2*WIDTH bits
//   carry_flag add carry-out / sub borrow
//   err_flag   reserved opcode or divide by zero
//   busy       multi-cycle operation in progress
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [2:0]         op_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               zero_flag,
   output logic               carry_flag,
   output logic               err_flag,
   output logic               busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
`ifdef ALU_SEQ_DIV_EN
   localparam logic [2:0] OP_DIV = 3'b110;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [CW-1:0]      cnt;
   // Engine registers: hi/lo hold partial product (mul) or remainder/quotient
   // (div); m holds the multiplicand or divisor.
   logic [WIDTH-1:0]   work_hi, work_lo, work_m;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     sum_ab;
   logic [2*WIDTH-1:0] sc_result;
   logic               sc_carry, sc_err, is_multi;
   logic               accept, last;
`ifdef ALU_SEQ_DIV_EN
   logic               is_div;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
`endif

   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign out_valid = (state == DONE);
   assign busy      = (state == EXEC);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST_STEP);
   assign sum_ab    = {1'b0, op_a} + {1'b0, op_b};

   // Single-cycle result decode, evaluated on the operands being accepted.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      sc_result = '0;
      sc_carry  = 1'b0;
      sc_err    = 1'b0;
      is_multi  = 1'b0;
      case (op_sel)
         OP_ADD: begin
            sc_result = {{(WIDTH-1){1'b0}}, sum_ab};
            sc_carry  = sum_ab[WIDTH];
         end
         OP_SUB: begin
            sc_result = {{WIDTH{1'b0}}, op_a - op_b};
            sc_carry  = (op_a < op_b);
         end
         OP_AND: sc_result = {{WIDTH{1'b0}}, op_a & op_b};
         OP_OR:  sc_result = {{WIDTH{1'b0}}, op_a | op_b};
         OP_XOR: sc_result = {{WIDTH{1'b0}}, op_a ^ op_b};
         OP_MUL: is_multi  = 1'b1;
`ifdef ALU_SEQ_DIV_EN
         OP_DIV: begin
            // Divide by zero skips the engine and reports immediately.
            if (op_b == '0) begin
               sc_result = '1;
               sc_err    = 1'b1;
            end else begin
               is_multi  = 1'b1;
            end
         end
`endif
         default: sc_err = 1'b1;
      endcase
   end

   // One iteration of the multi-cycle engine.
   always_comb begin
      // Shift-add: conditionally add the multiplicand to the upper half, then
      // shift the {hi, lo} pair right; the multiplier drains out of lo.
      mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? work_m : '0)};
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
      // Restoring division: shift the next dividend bit into the remainder
      // and subtract the divisor only if it fits. The remainder stays below
      // the divisor, so WIDTH bits suffice after the subtract.
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, work_m});
      if (is_div) begin
         step_hi = div_ge ? (div_shift[WIDTH-1:0] - work_m) : div_shift[WIDTH-1:0];
         step_lo = {work_lo[WIDTH-2:0], div_ge};
      end
`endif
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      if (accept) begin
         state_n = is_multi ? EXEC : DONE;
      end else begin
         case (state)
            EXEC:    if (last) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state is written with non-blocking assignments so
         // every register samples values from before the clock edge.
         state      <= IDLE;
         cnt        <= '0;
         work_hi    <= '0;
         work_lo    <= '0;
         work_m     <= '0;
         result     <= '0;
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
         err_flag   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         is_div     <= 1'b0;
`endif
      end else begin
         state <= state_n;
         if (accept) begin
            if (is_multi) begin
               work_hi <= '0;
               work_lo <= op_a;
               work_m  <= op_b;
               cnt     <= '0;
`ifdef ALU_SEQ_DIV_EN
               is_div  <= (op_sel == OP_DIV);
`endif
            end else begin
               result     <= sc_result;
               zero_flag  <= (sc_result == '0);
               carry_flag <= sc_carry;
               err_flag   <= sc_err;
            end
         end else if (state == EXEC) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
            cnt     <= cnt + CW'(1);
            // Flags are derived from the value being written, not the
            // previously held result.
            if (last) begin
               result     <= {step_hi, step_lo};
               zero_flag  <= ({step_hi, step_lo} == '0);
               carry_flag <= 1'b0;
               err_flag   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed, self-checking bench for alu_seq at WIDTH=8.
// Covers reset (including reset during a multiply), add/sub/logic results,
// back-to-back issue, output back-pressure, multiply latency, reserved
// opcodes and, when ALU_SEQ_DIV_EN is defined, division.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int WIDTH = 8;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [2:0]         op_sel;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] result;
   logic               zero_flag;
   logic               carry_flag;
   logic               err_flag;
   logic               busy;

   int tests = 0;
   int fails = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_sel     (op_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .err_flag   (err_flag),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one command (in_ready must be high) and wait, bounded, for the
   // result. lat is the number of edges from acceptance to out_valid.
   task automatic run_op(input logic [2:0] sel, input logic [7:0] a,
                         input logic [7:0] b, output int lat);
      op_sel   = sel;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   initial begin
      int lat;
      logic stray;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op_a      = '0;
      op_b      = '0;
      op_sel    = 3'b000;
      step();
      step();

      // Reset state.
      check("rst_out_valid", out_valid, 0);
      check("rst_busy",      busy,      0);
      check("rst_result",    result,    0);
      check("rst_flags",     {zero_flag, carry_flag, err_flag}, 0);
      rst = 1'b0;
      step();
      check("rst_in_ready",  in_ready,  1);

      // Reset asserted in the middle of a multiply.
      op_sel = 3'b100; op_a = 8'd3; op_b = 8'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("mid_busy",     busy,     1);
      check("mid_in_ready", in_ready, 0);
      step();
      step();
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy",      busy,      0);
      check("abort_result",    result,    0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("abort_in_ready", in_ready, 1);
      stray = 1'b0;
      for (int i = 0; i < 12; i++) begin
         stray = stray | out_valid;
         step();
      end
      check("abort_no_stray", stray, 0);

      // add 200+100, then sub 5-7 issued while the add result drains.
      op_sel = 3'b000; op_a = 8'd200; op_b = 8'd100; in_valid = 1'b1;
      step();
      check("add_valid",  out_valid,  1);
      check("add_result", result,     16'h012C);
      check("add_carry",  carry_flag, 1);
      check("add_zero",   zero_flag,  0);
      check("add_ready",  in_ready,   1);
      op_sel = 3'b001; op_a = 8'd5; op_b = 8'd7;
      step();
      in_valid = 1'b0;
      check("sub_valid",  out_valid,  1);
      check("sub_result", result,     16'h00FE);
      check("sub_carry",  carry_flag, 1);
      step();
      check("sub_drain",  out_valid,  0);

      // mul 255*255; inputs keep toggling and in_valid stays high during EXEC.
      op_sel = 3'b100; op_a = 8'd255; op_b = 8'd255; in_valid = 1'b1;
      step();
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("mul_busy_c%0d", i),     busy,      1);
         check($sformatf("mul_in_ready_c%0d", i), in_ready,  0);
         check($sformatf("mul_valid_c%0d", i),    out_valid, 0);
         op_sel = 3'b000;
         op_a   = 8'(i);
         op_b   = 8'(i * 3);
         in_valid = (i < 8);
         step();
      end
      check("mul_valid",  out_valid,  1);
      check("mul_busy",   busy,       0);
      check("mul_result", result,     16'hFE01);
      check("mul_carry",  carry_flag, 0);
      check("mul_zero",   zero_flag,  0);
      step();
      check("mul_drain",  out_valid,  0);

      // Back-to-back logic ops, one per clock.
      op_sel = 3'b010; op_a = 8'h0F; op_b = 8'hF0; in_valid = 1'b1;
      step();
      check("and_result", result,    16'h0000);
      check("and_zero",   zero_flag, 1);
      check("and_valid",  out_valid, 1);
      op_sel = 3'b011;
      step();
      check("or_result",  result,    16'h00FF);
      check("or_zero",    zero_flag, 0);
      check("or_valid",   out_valid, 1);
      op_sel = 3'b101; op_a = 8'hAA; op_b = 8'h0F;
      step();
      check("xor_result", result,    16'h00A5);
      check("xor_valid",  out_valid, 1);
      in_valid = 1'b0;
      step();
      check("logic_drain", out_valid, 0);

      // Back-pressure: result held for 5 cycles, new command waits.
      out_ready = 1'b0;
      op_sel = 3'b010; op_a = 8'h3C; op_b = 8'h0F; in_valid = 1'b1;
      step();
      op_sel = 3'b000; op_a = 8'd1; op_b = 8'd1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold_result_c%0d", i),   result,    16'h000C);
         check($sformatf("hold_valid_c%0d", i),    out_valid, 1);
         check($sformatf("hold_in_ready_c%0d", i), in_ready,  0);
         check($sformatf("hold_flags_c%0d", i),    {zero_flag, carry_flag, err_flag}, 0);
         step();
      end
      op_sel = 3'b001; op_a = 8'h10; op_b = 8'h10;
      out_ready = 1'b1;
      #1;
      check("release_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("release_result", result,     16'h0000);
      check("release_zero",   zero_flag,  1);
      check("release_carry",  carry_flag, 0);
      check("release_valid",  out_valid,  1);
      step();
      check("release_drain",  out_valid,  0);

      // Reserved opcode and assorted boundaries.
      run_op(3'b111, 8'd5, 8'd3, lat);
      check("rsv_latency", lat,       1);
      check("rsv_result",  result,    16'h0000);
      check("rsv_err",     err_flag,  1);
      check("rsv_zero",    zero_flag, 1);
      run_op(3'b000, 8'd255, 8'd1, lat);
      check("add_wrap_result", result,     16'h0100);
      check("add_wrap_carry",  carry_flag, 1);
      check("add_wrap_zero",   zero_flag,  0);
      check("add_wrap_err",    err_flag,   0);
      run_op(3'b001, 8'd7, 8'd5, lat);
      check("sub_pos_result", result,     16'h0002);
      check("sub_pos_carry",  carry_flag, 0);
      run_op(3'b100, 8'd0, 8'd77, lat);
      check("mul0_latency", lat,        9);
      check("mul0_result",  result,     16'h0000);
      check("mul0_zero",    zero_flag,  1);
      run_op(3'b100, 8'd13, 8'd11, lat);
      check("mul_small_latency", lat,    9);
      check("mul_small_result",  result, 16'h008F);
      check("mul_small_zero",    zero_flag, 0);

`ifdef ALU_SEQ_DIV_EN
      run_op(3'b110, 8'd200, 8'd7, lat);
      check("div_latency", lat,      9);
      check("div_result",  result,   16'h041C);
      check("div_err",     err_flag, 0);
      run_op(3'b110, 8'd9, 8'd0, lat);
      check("div0_latency", lat,      1);
      check("div0_result",  result,   16'hFFFF);
      check("div0_err",     err_flag, 1);
`else
      run_op(3'b110, 8'd200, 8'd7, lat);
      check("op110_latency", lat,      1);
      check("op110_result",  result,   16'h0000);
      check("op110_err",     err_flag, 1);
`endif

      step();
      check("final_idle_valid", out_valid, 0);
      check("final_in_ready",   in_ready,  1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
